// File: rtl/mips_regfile_if.sv
// mips_regfile_if
//   Bus between the pipeline (ID-stage reads, WB-stage writes, load-use
//   scoreboard updates, debug fixture) and the register file.
//   Signals:
//     we/waddr/wdata        write port (WB stage)
//     raddr1/raddr2         read addresses (ID stage)
//     rdata1/rdata2         combinational read data
//     rbusy1/rbusy2         combinational busy flags for raddr1/raddr2
//     busy_set/busy_addr    mark a register as having a write in flight
//     dbg_addr/dbg_rdata    registered debug read port
//     busy_count            registered number of busy registers
//   Modports: master = pipeline side, slave = register file side.
interface mips_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rbusy1;
    logic              rbusy2;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr, dbg_addr,
        input  rdata1, rdata2, rbusy1, rbusy2, dbg_rdata, busy_count
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr, dbg_addr,
        output rdata1, rdata2, rbusy1, rbusy2, dbg_rdata, busy_count
    );
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile
//   Parametrised MIPS register file with optional hardwired zero register,
//   optional write-to-read bypass, a per-register busy scoreboard for
//   load-use hazard detection and a registered debug read port.
//   Ports:
//     clk   rising-edge clock for all state
//     rst   synchronous active-high reset (clears data, busy bits, debug
//           data and busy_count; overrides writes and busy marks)
//     bus   mips_regfile_if.slave (see interface header for signal list)
module mips_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    mips_regfile_if.slave bus
);
    localparam int   NREGS   = 2 ** ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  busy_r;
    logic [NREGS-1:0]  busy_nxt_s;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic [ADDR_W:0]   busy_count_r;
    logic              wr_en_s;
    logic              fwd1_s;
    logic              fwd2_s;

    // Read mux shared by both ID ports and the debug port: zero register
    // first, then same-cycle forwarding of the WB write, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] val;
        if (ZERO_EN && (addr == {ADDR_W{1'b0}})) begin
            val = {DATA_W{1'b0}};
        end else if (BYP_EN && we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Write qualification and forwarding hits for the busy masking.
    always_comb begin
        wr_en_s = bus.we & ~(ZERO_EN & (bus.waddr == {ADDR_W{1'b0}}));
        fwd1_s  = BYP_EN & bus.we & (bus.waddr == bus.raddr1);
        fwd2_s  = BYP_EN & bus.we & (bus.waddr == bus.raddr2);
    end

    // Next busy vector: a retiring write clears its bit, a new producer sets
    // its bit and wins on a collision; register 0 never turns busy.
    always_comb begin
        busy_nxt_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            busy_nxt_s[i] = ((busy_r[i] & ~(bus.we & (bus.waddr == ADDR_W'(i))))
                             | (bus.busy_set & (bus.busy_addr == ADDR_W'(i))))
                            & ~(ZERO_EN & (i == 0));
        end
    end

    // Combinational ID-stage read data and busy flags.
    always_comb begin
        bus.rdata1 = read_port(bus.raddr1, regs_r[bus.raddr1], bus.we, bus.waddr, bus.wdata);
        bus.rdata2 = read_port(bus.raddr2, regs_r[bus.raddr2], bus.we, bus.waddr, bus.wdata);
        bus.rbusy1 = busy_r[bus.raddr1] & ~fwd1_s;
        bus.rbusy2 = busy_r[bus.raddr2] & ~fwd2_s;
    end

    // Storage, scoreboard, debug read and busy count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            busy_r       <= {NREGS{1'b0}};
            dbg_rdata_r  <= {DATA_W{1'b0}};
            busy_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                regs_r[bus.waddr] <= bus.wdata;
            end
            busy_r       <= busy_nxt_s;
            dbg_rdata_r  <= read_port(bus.dbg_addr, regs_r[bus.dbg_addr],
                                      bus.we, bus.waddr, bus.wdata);
            // Counts the vector as it stood during this cycle, so it trails
            // the busy bits by one edge.
            busy_count_r <= popcount(busy_r);
        end
    end

    assign bus.dbg_rdata  = dbg_rdata_r;
    assign bus.busy_count = busy_count_r;
endmodule
